// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] INST_NOP = 32'h00000013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        trap;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry shift FIFO of fetch entries with registered head and flush.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [FETCH_DEPTH];
  logic pop_en, push_en;
  logic [1:0] idx;
  assign pop_en = pop && count != 2'd0;
  assign idx = count - {1'b0, pop_en};
  assign push_en = push && idx < 2'd2;
  assign head = mem[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= {1'b0, push};
      mem[0] <= push ? din : '0;
      mem[1] <= '0;
    end else begin
      count <= idx + {1'b0, push_en};
      if (pop_en) mem[0] <= mem[1];
      if (push_en) mem[idx[0]] <= din;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop && count == 2'd2))
    else $fatal(1, "fetch_fifo: enqueue into full queue");
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order fetches with credit gating,
// tags responses with their PC and discards fetches made stale by redirects.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap,
  input  logic        i_inst_ready
);
  logic [31:0] pc;
  logic [31:0] tag [FETCH_DEPTH];
  logic [1:0] outstanding, drop, count;
  logic halted, hs, resp, misaligned, push, tidx;
  logic [2:0] occ;
  fetch_entry_t din, head;
  assign occ = {1'b0, outstanding} + {1'b0, count};
  assign o_imem_req_valid = !i_rst && !halted && !i_redirect_valid && occ < 3'd2;
  assign o_imem_req_addr = pc;
  assign hs = o_imem_req_valid && i_imem_req_ready;
  // Responses with nothing outstanding cannot belong to us and are ignored.
  assign resp = i_imem_resp_valid && outstanding != 2'd0;
  assign misaligned = i_redirect_pc[1:0] != 2'b00;
  assign push = i_redirect_valid ? misaligned : resp && drop == 2'd0;
  assign din = i_redirect_valid ? {i_redirect_pc, 32'h0, 1'b1} : {tag[0], i_imem_resp_rdata, 1'b0};
  assign tidx = outstanding[0] && !resp;
  assign o_inst_valid = count != 2'd0;
  assign o_inst = o_inst_valid ? head.inst : 32'h0;
  assign o_inst_pc = o_inst_valid ? head.pc : 32'h0;
  assign o_inst_trap = o_inst_valid && head.trap;
  fetch_fifo u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (i_inst_ready),
    .flush (i_redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= RESET_ADDR;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      halted      <= 1'b0;
      tag[0]      <= 32'h0;
      tag[1]      <= 32'h0;
    end else begin
      outstanding <= outstanding + {1'b0, hs} - {1'b0, resp};
      if (resp) tag[0] <= tag[1];
      if (hs) tag[tidx] <= pc;
      if (i_redirect_valid) begin
        pc     <= i_redirect_pc;
        halted <= misaligned;
        drop   <= outstanding - {1'b0, resp};
      end else begin
        if (hs) pc <= pc + 32'd4;
        if (resp && drop != 2'd0) drop <= drop - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-1 in-order memory model.
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready = 1'b1;
  logic [31:0] req_addr;
  logic resp_valid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic inst_valid, inst_trap, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic stall = 1'b0, mon_en = 1'b0;
  logic [31:0] pend [$];
  logic [31:0] exp_req, exp_inst, first_req;
  int vectors = 0, misses = 0;
  bit found, req_seen, bad;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_ADDR(32'h0)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_imem_req_valid  (req_valid),
    .o_imem_req_addr   (req_addr),
    .i_imem_req_ready  (req_ready),
    .i_imem_resp_valid (resp_valid),
    .i_imem_resp_rdata (rdata),
    .i_redirect_valid  (redirect),
    .i_redirect_pc     (redirect_pc),
    .o_inst_valid      (inst_valid),
    .o_inst            (inst),
    .o_inst_pc         (inst_pc),
    .o_inst_trap       (inst_trap),
    .i_inst_ready      (inst_ready)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ 32'h00001013 ^ (a >> 2);
  endfunction

  // Memory: responds one cycle after acceptance, in order, unless stalled.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      resp_valid <= 1'b0;
    end else begin
      if (req_valid && req_ready) pend.push_back(req_addr);
      if (!stall && pend.size() > 0) begin
        resp_valid <= 1'b1;
        rdata <= word_at(pend.pop_front());
      end else begin
        resp_valid <= 1'b0;
        rdata <= 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] pc_exp);
    found = 1'b0;
    req_seen = 1'b0;
    first_req = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) begin
      if (!req_seen && req_valid) begin
        first_req = req_addr;
        req_seen = 1'b1;
      end
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk({tag, "_found"}, {31'b0, found}, 32'd1);
    chk({tag, "_first_req"}, first_req, pc_exp);
    chk({tag, "_pc"}, inst_pc, pc_exp);
    chk({tag, "_inst"}, inst, word_at(pc_exp));
    chk({tag, "_trap"}, {31'b0, inst_trap}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_valid && req_ready) begin
        chk("stream_req_addr", req_addr, exp_req);
        exp_req += 32'd4;
      end
      if (inst_valid && inst_ready) begin
        chk("stream_pc", inst_pc, exp_inst);
        chk("stream_inst", inst, word_at(exp_inst));
        exp_inst += 32'd4;
      end
      chk("max_outstanding", {31'b0, (pend.size() + int'(resp_valid)) <= 2}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and first fetches with decode stalled: queue fills with 0x0, 0x4.
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_trap", {31'b0, inst_trap}, 32'd0);
    rst = 1'b0;
    #1;
    chk("c0_req_valid", {31'b0, req_valid}, 32'd1);
    chk("c0_req_addr", req_addr, 32'h0);
    chk("c0_inst_valid", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("c1_req_valid", {31'b0, req_valid}, 32'd1);
    chk("c1_req_addr", req_addr, 32'h4);
    chk("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("c2_inst_pc", inst_pc, 32'h0);
    chk("c2_inst", inst, word_at(32'h0));
    chk("c2_req_valid", {31'b0, req_valid}, 32'd0);
    repeat (7) cyc();
    chk("full_req_valid", {31'b0, req_valid}, 32'd0);
    chk("full_inst_pc", inst_pc, 32'h0);
    chk("full_outstanding", pend.size() + int'(resp_valid), 32'd0);
    // Release decode; the stream must continue 0x0, 0x4, 0x8, ... with no gaps.
    exp_req = 32'h8;
    exp_inst = 32'h0;
    mon_en = 1'b1;
    inst_ready = 1'b1;
    repeat (20) cyc();
    mon_en = 1'b0;
    chk("stream_progress", {31'b0, exp_inst >= 32'h20}, 32'd1);

    // Two outstanding (0x8, 0xC) then redirect to 0x100.
    do_reset();
    repeat (3) cyc();
    chk("r3_req_addr", req_addr, 32'h8);
    stall = 1'b1;
    cyc();
    chk("r4_req_addr", req_addr, 32'hC);
    cyc();
    chk("r5_req_valid", {31'b0, req_valid}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    stall = 1'b0;
    #1;
    chk("redir_gate", {31'b0, req_valid}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    wait_inst("redir100", 32'h100);

    // Misaligned redirect traps and halts fetch until an aligned redirect.
    redirect = 1'b1;
    redirect_pc = 32'h102;
    #1;
    chk("trap_gate", {31'b0, req_valid}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("trap_valid", {31'b0, inst_valid}, 32'd1);
    chk("trap_flag", {31'b0, inst_trap}, 32'd1);
    chk("trap_pc", inst_pc, 32'h102);
    chk("trap_inst", inst, 32'h0);
    chk("trap_req_valid", {31'b0, req_valid}, 32'd0);
    bad = 1'b0;
    repeat (6) begin
      cyc();
      if (req_valid) bad = 1'b1;
    end
    chk("halt_no_req", {31'b0, bad}, 32'd0);
    chk("halt_queue_empty", {31'b0, inst_valid}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    #1;
    wait_inst("redir200", 32'h200);

    // Response and redirect in the same cycle with one outstanding.
    do_reset();
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    #1;
    chk("same_gate", {31'b0, req_valid}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("same_req_valid", {31'b0, req_valid}, 32'd1);
    chk("same_req_addr", req_addr, 32'h300);
    chk("same_inst_valid", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("same_inst_valid2", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("same_inst_valid3", {31'b0, inst_valid}, 32'd1);
    chk("same_inst_pc", inst_pc, 32'h300);
    chk("same_inst", inst, word_at(32'h300));

    // Reset while the queue is full.
    inst_ready = 1'b0;
    repeat (8) cyc();
    chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
    chk("pre_rst_pc", inst_pc, 32'h300);
    rst = 1'b1;
    cyc();
    chk("mid_rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    chk("mid_rst_trap", {31'b0, inst_trap}, 32'd0);
    rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    wait_inst("restart", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
